// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: register bank behind the I2C slave byte engine.
// The first byte after START or repeated START loads the register pointer.
// Each following byte is written to the register at the pointer, and the
// pointer then advances. Each transmit request also advances the pointer.
// A host port gives FPGA-side read/write access to the same registers.
// Optional feature: define I2C_REGFILE_WRITE_PROTECT_EN to make the
// registers flagged in RO_MASK read-only from the I2C side.
module i2c_slave_regfile #(
  parameter int unsigned                 ADDR_W    = 4,
  parameter logic [7:0]                  RESET_VAL = 8'h00,
  parameter logic [(2**ADDR_W)-1:0]      RO_MASK   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_phase,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              host_collision,
  output logic [ADDR_W-1:0] ptr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_WAIT_PTR = 1'b0,
    ST_DATA     = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        regs [DEPTH];

  logic ap_q, rx_q, tx_q;
  logic ap_ev, rx_ev, tx_ev;
  logic i2c_we;
  logic host_hit;

`ifndef I2C_REGFILE_WRITE_PROTECT_EN
  logic unused_ro_mask;
  assign unused_ro_mask = ^RO_MASK;
`endif

  assign ap_ev    = addr_phase & ~ap_q;
  assign rx_ev    = rx_valid   & ~rx_q;
  assign tx_ev    = tx_req     & ~tx_q;
  assign host_hit = i2c_we && (host_addr == ptr_q);
  assign ptr      = ptr_q;

  // Edge-detect history for the three slave-engine level signals.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ap_q <= 1'b0;
      rx_q <= 1'b0;
      tx_q <= 1'b0;
    end else begin
      ap_q <= addr_phase;
      rx_q <= rx_valid;
      tx_q <= tx_req;
    end
  end

  // FSM state and register pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_WAIT_PTR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state, next pointer and I2C write enable.
  // The priority order is: addr_phase event, then rx event, then tx event.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    i2c_we  = 1'b0;
    if (ap_ev) begin
      state_d = ST_WAIT_PTR;
    end else if (rx_ev) begin
      unique case (state_q)
        ST_WAIT_PTR: begin
          ptr_d   = rx_data[ADDR_W-1:0];
          state_d = ST_DATA;
        end
        ST_DATA: begin
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
          i2c_we = ~RO_MASK[ptr_q];
`else
          i2c_we = 1'b1;
`endif
          ptr_d  = ptr_q + ADDR_W'(1);
        end
        default: state_d = ST_WAIT_PTR;
      endcase
    end else if (tx_ev) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // Register array: the I2C write wins on an index clash with the host.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      if (i2c_we) begin
        regs[ptr_q] <= rx_data;
      end
      if (host_we && !host_hit) begin
        regs[host_addr] <= host_wdata;
      end
    end
  end

  // Registered read ports, commit pulses and collision pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_data        <= RESET_VAL;
      host_rdata     <= RESET_VAL;
      wr_strobe      <= 1'b0;
      wr_addr        <= '0;
      host_collision <= 1'b0;
    end else begin
      tx_data        <= regs[ptr_q];
      host_rdata     <= regs[host_addr];
      wr_strobe      <= i2c_we;
      host_collision <= host_we && host_hit;
      if (i2c_we) begin
        wr_addr <= ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed testbench for i2c_slave_regfile.
// Inputs are driven on the negedge, and outputs are sampled on the negedge.
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       reset;
  logic       addr_phase;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic [3:0] host_addr;
  logic       host_we;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       host_collision;
  logic [3:0] ptr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .ADDR_W   (4),
    .RESET_VAL(8'h00),
    .RO_MASK  (16'h0002)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .addr_phase    (addr_phase),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_req        (tx_req),
    .tx_data       (tx_data),
    .host_addr     (host_addr),
    .host_we       (host_we),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .host_collision(host_collision),
    .ptr           (ptr)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ap_pulse();
    addr_phase = 1'b1;
    tick();
    addr_phase = 1'b0;
    tick();
  endtask

  task automatic tx_pulse();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    tick();
  endtask

  // One received byte. Checks the commit pulse and confirms that it lasts one cycle.
  task automatic rx_byte(input logic [7:0] b, input logic exp_stb, input logic [3:0] exp_addr,
                         input string tag);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    chk({tag, "_stb"}, 32'(wr_strobe), 32'(exp_stb));
    if (exp_stb) chk({tag, "_waddr"}, 32'(wr_addr), 32'(exp_addr));
    rx_valid = 1'b0;
    tick();
    chk({tag, "_stb_off"}, 32'(wr_strobe), 32'd0);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    host_addr = a;
    tick();
    chk(tag, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    reset      = 1'b0;
    addr_phase = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    tx_req     = 1'b0;
    host_addr  = 4'd0;
    host_we    = 1'b0;
    host_wdata = 8'h00;
    tick();
    tick();
    // Check the reset state.
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_tx", 32'(tx_data), 32'h00);
    chk("rst_hrd", 32'(host_rdata), 32'h00);
    chk("rst_stb", 32'(wr_strobe), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    chk("rst_coll", 32'(host_collision), 32'd0);
    reset = 1'b1;
    tick();

    // Pointer 3, then write two data bytes.
    ap_pulse();
    rx_byte(8'h03, 1'b0, 4'd0, "t1_ptr");
    chk("t1_ptr_val", 32'(ptr), 32'd3);
    rx_byte(8'hA5, 1'b1, 4'd3, "t1_w3");
    rx_byte(8'h5A, 1'b1, 4'd4, "t1_w4");
    chk("t1_ptr_end", 32'(ptr), 32'd5);
    host_read(4'd3, 8'hA5, "t1_reg3");
    host_read(4'd4, 8'h5A, "t1_reg4");

    // Start at pointer 15 and check that the pointer wraps to 0.
    ap_pulse();
    rx_byte(8'h0F, 1'b0, 4'd0, "t2_ptr");
    rx_byte(8'h11, 1'b1, 4'd15, "t2_w15");
    rx_byte(8'h22, 1'b1, 4'd0, "t2_w0");
    chk("t2_ptr_wrap", 32'(ptr), 32'd1);
    host_read(4'd15, 8'h11, "t2_reg15");
    host_read(4'd0, 8'h22, "t2_reg0");

    // Write pointer 2, then a repeated START, then two reads.
    host_write(4'd2, 8'hC2);
    ap_pulse();
    rx_byte(8'h82, 1'b0, 4'd0, "t3_ptr");
    ap_pulse();
    chk("t3_ptr_kept", 32'(ptr), 32'd2);
    chk("t3_tx_reg2", 32'(tx_data), 32'hC2);
    tx_pulse();
    chk("t3_tx_reg3", 32'(tx_data), 32'hA5);
    tx_pulse();
    chk("t3_tx_reg4", 32'(tx_data), 32'h5A);
    chk("t3_ptr4", 32'(ptr), 32'd4);
    host_read(4'd2, 8'hC2, "t3_reg2_same");
    host_read(4'd3, 8'hA5, "t3_reg3_same");

    // Host write and I2C write to the same index in the same cycle.
    ap_pulse();
    rx_byte(8'h05, 1'b0, 4'd0, "t4_ptr");
    rx_data    = 8'h33;
    rx_valid   = 1'b1;
    host_addr  = 4'd5;
    host_wdata = 8'h77;
    host_we    = 1'b1;
    tick();
    chk("t4_stb", 32'(wr_strobe), 32'd1);
    chk("t4_waddr", 32'(wr_addr), 32'd5);
    chk("t4_coll", 32'(host_collision), 32'd1);
    rx_valid = 1'b0;
    host_we  = 1'b0;
    tick();
    chk("t4_coll_off", 32'(host_collision), 32'd0);
    host_read(4'd5, 8'h33, "t4_reg5");
    // Host write and I2C write to different indices in the same cycle.
    ap_pulse();
    rx_byte(8'h07, 1'b0, 4'd0, "t4b_ptr");
    rx_data    = 8'h88;
    rx_valid   = 1'b1;
    host_addr  = 4'd6;
    host_wdata = 8'h66;
    host_we    = 1'b1;
    tick();
    chk("t4b_coll", 32'(host_collision), 32'd0);
    chk("t4b_waddr", 32'(wr_addr), 32'd7);
    rx_valid = 1'b0;
    host_we  = 1'b0;
    tick();
    host_read(4'd6, 8'h66, "t4b_reg6");
    host_read(4'd7, 8'h88, "t4b_reg7");

    // Register 1 is flagged read-only in RO_MASK.
    ap_pulse();
    rx_byte(8'h01, 1'b0, 4'd0, "t5_ptr");
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
    rx_byte(8'hFF, 1'b0, 4'd0, "t5_w1");
`else
    rx_byte(8'hFF, 1'b1, 4'd1, "t5_w1");
`endif
    rx_byte(8'hEE, 1'b1, 4'd2, "t5_w2");
    chk("t5_ptr", 32'(ptr), 32'd3);
`ifdef I2C_REGFILE_WRITE_PROTECT_EN
    host_read(4'd1, 8'h00, "t5_reg1");
`else
    host_read(4'd1, 8'hFF, "t5_reg1");
`endif
    host_read(4'd2, 8'hEE, "t5_reg2");

    // Reset between the pointer byte and the data byte.
    ap_pulse();
    rx_byte(8'h09, 1'b0, 4'd0, "t6_ptr");
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_ptr_rst", 32'(ptr), 32'd0);
    host_read(4'd3, 8'h00, "t6_reg3");
    host_read(4'd5, 8'h00, "t6_reg5");
    host_read(4'd15, 8'h00, "t6_reg15");
    rx_byte(8'h0A, 1'b0, 4'd0, "t6_newptr");
    chk("t6_ptr_a", 32'(ptr), 32'd10);
    rx_byte(8'h12, 1'b1, 4'd10, "t6_w10");
    host_read(4'd10, 8'h12, "t6_reg10");
    host_read(4'd9, 8'h00, "t6_reg9");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Register-bank back end sitting directly downstream of the I2C slave byte engine.
- Consumes received bytes (received / datareceive) and supplies transmit bytes (datasend on sended).
- I2C protocol: the first data byte after each START or repeated START is the register pointer. Following bytes are written to consecutive registers. Reads return consecutive registers from the pointer.
- A host-side port gives FPGA logic read/write access to the same registers.

Parameters:
- ADDR_W, 4: pointer/register index width; DEPTH = 2**ADDR_W registers.
- RESET_VAL, 8'h00: reset content of every register.
- RO_MASK, {DEPTH{1'b0}}: bit i set = register i is read-only from I2C. Only honoured with the optional feature enabled.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- addr_phase  in  1  high while the slave engine is receiving/acknowledging the address byte (START or repeated START seen).
- rx_data  in  8  slave datareceive.
- rx_valid  in  1  slave received (level); its rising edge marks a new data byte.
- tx_req  in  1  slave sended (level); its rising edge requests the next transmit byte.
- tx_data  out  8  to slave datasend.
- host_addr  in  ADDR_W  host register index.
- host_we  in  1  host write enable, one cycle.
- host_wdata  in  8  host write data.
- host_rdata  out  8  registered read of host_addr.
- wr_strobe  out  1  one-cycle pulse when an I2C write commits.
- wr_addr  out  ADDR_W  index of the committed I2C write; valid with wr_strobe.
- host_collision  out  1  one-cycle pulse when a host write was dropped.
- ptr  out  ADDR_W  current register pointer.

Behaviour:
- Reset values (reset low at a posedge):
  - all registers = RESET_VAL; ptr = 0; tx_data = RESET_VAL; host_rdata = RESET_VAL.
  - wr_strobe = 0; wr_addr = 0; host_collision = 0; FSM = ST_WAIT_PTR.
  - edge-detect history of addr_phase, rx_valid and tx_req = 0.
  - Reset mid-transaction aborts everything; no partial write survives.
- Edge detect: each of addr_phase, rx_valid and tx_req is registered once. An event is current high & previous low.
- FSM has two states:
  - ST_WAIT_PTR: on an rx event, ptr <= rx_data[ADDR_W-1:0] (upper bits ignored) and go to ST_DATA. No register write, no wr_strobe.
  - ST_DATA: on an rx event, reg[ptr] <= rx_data, wr_strobe = 1 and wr_addr = ptr on the next cycle, ptr <= ptr+1.
  - In any state, an addr_phase event forces ST_WAIT_PTR; ptr is kept. This covers write-pointer / repeated-START / read sequences.
- tx event (either state): ptr <= ptr+1.
- Pointer arithmetic is modulo DEPTH: DEPTH-1 wraps to 0, with no flag.
- tx_data <= reg[ptr] every cycle. It is therefore valid ≤2 cycles after any ptr change or register write. The slave samples it only after SCL activity, many cycles later.
- The first read byte after address ACK uses tx_data without a tx event, so reg[ptr] at that moment is sent.
- Simultaneous events in one cycle:
  - addr_phase event wins over an rx or tx event in the same cycle; the rx/tx event is dropped.
  - rx and tx events together cannot occur legally; if they do, rx is processed and tx ignored.
- Host port:
  - host_rdata <= reg[host_addr], 1-cycle latency.
  - A host write commits at the posedge with host_we = 1.
  - If an I2C write commits to the same index in the same cycle, the I2C write wins, the host write is dropped, and host_collision pulses the next cycle.
  - A host write to a different index commits in parallel.
- wr_strobe and host_collision are single-cycle pulses. They never stay high two consecutive cycles unless two events occur in consecutive cycles.

Optional Feature:
- Macro I2C_REGFILE_WRITE_PROTECT_EN.
- When defined, an I2C write to index i with RO_MASK[i] = 1 is discarded: no register change, no wr_strobe. ptr still increments. Host writes are unaffected.
- When undefined, RO_MASK is ignored and all registers are I2C-writable.

Test Plan:
- Reset, then addr_phase pulse, rx bytes 8'h03, 8'hA5, 8'h5A -> reg3 = A5 and reg4 = 5A; wr_strobe pulses with wr_addr 3 then 4; final ptr = 5.
- Write pointer 8'h0F followed by 8'h11, 8'h22 -> reg15 = 11, reg0 = 22, ptr = 1 (wrap).
- addr_phase, rx 8'h02, addr_phase again (repeated START), then two tx events -> tx_data shows reg2 first, then reg3, then reg4; no register modified.
- Host write reg5 = 8'h77 in the same cycle as an I2C write reg5 = 8'h33 -> reg5 = 33, host_collision pulses once. Host write to reg6 in the same cycle commits.
- With I2C_REGFILE_WRITE_PROTECT_EN and RO_MASK bit 1 set: ptr 1, write 8'hFF, 8'hEE -> reg1 unchanged, reg2 = EE, single wr_strobe (addr 2). Without the macro, reg1 = FF.
- Assert reset between the pointer byte and the data byte -> after release, all registers = RESET_VAL, FSM = ST_WAIT_PTR, and the next rx byte is treated as the pointer.
